// File: rtl/serial_decrypt_receiver.sv
// rtl/serial_decrypt_receiver.sv - framed serial receiver that decrypts each character into a plaintext FIFO
// The decrypt network undoes the messenger encrypter; the FIFO head is presented from a register.
module serial_decrypt_receiver #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  input  logic [7:0] key,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       framing_error,
  output logic       overflow,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] MID_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [7:0]    t, plain, head_nxt;
  logic          stop_sample, push, pop, full, push_ok;

  always_comb begin
    t           = shreg ^ key;
    plain       = {t[7], ~t[6], t[3], ~t[4], t[1], ~t[2], t[5], ~t[0]};
    stop_sample = (state == STOP) && (cnt == LAST_CNT);
    push        = stop_sample && serial_in;
    pop         = out_valid && out_ready;
    full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push_ok     = push && (!full || pop);
    wr_ptr_nxt  = wr_ptr + {{AW{1'b0}}, push_ok};
    rd_ptr_nxt  = rd_ptr + {{AW{1'b0}}, pop};
    // A push into a FIFO that will be empty must bypass the array to reach the head register.
    if (push_ok && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]))
      head_nxt = plain;
    else
      head_nxt = mem[rd_ptr_nxt[AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      busy          <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!serial_in) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == MID_CNT) begin
            cnt <= '0;
            idx <= '0;
            if (!serial_in) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt        <= '0;
            shreg[idx] <= serial_in;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          // Leave half a bit early so a back-to-back start bit is not missed.
          if (stop_sample) begin
            state         <= IDLE;
            cnt           <= '0;
            busy          <= 1'b0;
            framing_error <= !serial_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_char  <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      out_valid <= (wr_ptr_nxt != rd_ptr_nxt);
      out_char  <= head_nxt;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= plain;
  end
endmodule

// File: tb/tb_serial_decrypt_receiver.sv
// tb/tb_serial_decrypt_receiver.sv - directed self-checking bench for serial_decrypt_receiver
module tb_serial_decrypt_receiver;
  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset, serial_in, out_ready;
  logic       out_valid, framing_error, overflow, busy;
  logic [7:0] key, out_char;
  int         total = 0;
  int         bad = 0;
  logic       vb, va, fa, fn, oa;
  logic [7:0] ca;

  serial_decrypt_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .serial_in(serial_in),
    .key(key),
    .out_char(out_char),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .framing_error(framing_error),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  // Stop bit: sampled on its 3rd edge; results captured just before and after that edge and one edge later.
  task automatic send_frame(input logic [7:0] c, input logic stop, input logic pop_at_sample,
                            output logic v_before, output logic v_after, output logic fe_after,
                            output logic fe_next, output logic ov_after, output logic [7:0] ch_after);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(c[i]);
    serial_in = stop;
    repeat (2) @(posedge clock);
    #1;
    v_before = out_valid;
    if (pop_at_sample) out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    v_after  = out_valid;
    fe_after = framing_error;
    ov_after = overflow;
    ch_after = out_char;
    @(posedge clock);
    #1;
    fe_next   = framing_error;
    serial_in = 1'b1;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, out_valid, 1'b1);
    check(tag, out_char, exp);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    serial_in = 1'b1;
    out_ready = 1'b0;
    key       = 8'h2B;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_char", out_char, 8'h00);
    check("rst_fe", framing_error, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // single frame 0x3F -> 'A'
    send_frame(8'h3F, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    check("t1_valid_before", vb, 1'b0);
    check("t1_valid_after", va, 1'b1);
    check("t1_char", ca, 8'h41);
    check("t1_fe", fa, 1'b0);
    check("t1_busy_idle", busy, 1'b0);
    pop_expect("t1_pop", 8'h41);
    check("t1_empty", out_valid, 1'b0);

    // back-to-back frames, no idle gap
    send_frame(8'h3F, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    send_frame(8'h3C, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    check("t2_head", ca, 8'h41);
    pop_expect("t2_pop_a", 8'h41);
    pop_expect("t2_pop_h", 8'h48);
    check("t2_empty", out_valid, 1'b0);

    // stop bit forced low
    send_frame(8'h3F, 1'b0, 1'b0, vb, va, fa, fn, oa, ca);
    check("t3_fe_pulse", fa, 1'b1);
    check("t3_fe_clear", fn, 1'b0);
    check("t3_no_write", va, 1'b0);
    check("t3_no_ovf", oa, 1'b0);
    repeat (6) @(posedge clock);
    #1;
    check("t3_busy_idle", busy, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    check("t3_next_char", ca, 8'h48);
    check("t3_next_fe", fa, 1'b0);
    pop_expect("t3_pop", 8'h48);
    check("t3_empty", out_valid, 1'b0);

    // one-cycle glitch on the line
    serial_in = 1'b0;
    @(posedge clock);
    #1;
    check("t4_busy_start", busy, 1'b1);
    serial_in = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("t4_busy_idle", busy, 1'b0);
    check("t4_no_data", out_valid, 1'b0);
    check("t4_no_fe", framing_error, 1'b0);

    // five frames into a depth-4 FIFO; third uses a different key
    send_frame(8'h3F, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    send_frame(8'h3C, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    key = 8'h00;
    send_frame(8'h14, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    key = 8'h2B;
    send_frame(8'h3C, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    check("t5_ovf_at_full", oa, 1'b0);
    send_frame(8'h3F, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    check("t5_ovf_set", oa, 1'b1);
    pop_expect("t5_pop0", 8'h41);
    pop_expect("t5_pop1", 8'h48);
    pop_expect("t5_pop2_key0", 8'h41);
    pop_expect("t5_pop3", 8'h48);
    check("t5_empty", out_valid, 1'b0);
    check("t5_ovf_sticky", overflow, 1'b1);

    // reset in the middle of the data bits
    send_frame(8'h3C, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("t6_busy_mid", busy, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("t6_busy_rst", busy, 1'b0);
    check("t6_valid_rst", out_valid, 1'b0);
    check("t6_ovf_rst", overflow, 1'b0);
    reset     = 1'b0;
    serial_in = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("t6_still_empty", out_valid, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    check("t6_char", ca, 8'h48);
    check("t6_valid", va, 1'b1);
    pop_expect("t6_pop", 8'h48);

    // push while full coinciding with a pop
    send_frame(8'h3F, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    send_frame(8'h3C, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    send_frame(8'h3F, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    send_frame(8'h3C, 1'b1, 1'b0, vb, va, fa, fn, oa, ca);
    send_frame(8'h3F, 1'b1, 1'b1, vb, va, fa, fn, oa, ca);
    check("t7_no_ovf", oa, 1'b0);
    check("t7_head", ca, 8'h48);
    pop_expect("t7_pop0", 8'h48);
    pop_expect("t7_pop1", 8'h41);
    pop_expect("t7_pop2", 8'h48);
    pop_expect("t7_pop3", 8'h41);
    check("t7_empty", out_valid, 1'b0);
    check("t7_ovf_final", overflow, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
